// File: rtl/hw3_pkg.sv
// Shared definitions for the HW3 "1101101" detector stream controller.
package hw3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [6:0] PATTERN    = 7'b1101101;
    localparam int         DEF_WORD_W = 8;
    localparam int         DEF_CNT_W  = 8;

    // True when the newest seven serial bits (oldest in bit 6) form the pattern.
    function automatic logic pattern_hit(input logic [6:0] window);
        return window == PATTERN;
    endfunction

endpackage

// File: rtl/hw3_match_cnt.sv
// Saturating count of detector hits with a sticky threshold interrupt.
module hw3_match_cnt
    import hw3_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_find,
    input  logic [CNT_W-1:0] i_thresh,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             irq_q, irq_d;

    // Next count/irq: clear wins and swallows a same-edge find; count sticks at all-ones.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        if (i_clear) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else if (i_find) begin
            cnt_d = cnt_inc;
            if ((cnt_inc == i_thresh) && (i_thresh != '0)) begin
                irq_d = 1'b1;
            end
        end
    end

    // Count and irq registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            irq_q <= irq_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_irq = irq_q;

endmodule

// File: rtl/hw3_det_ctrl.sv
// Feeds parallel words MSB-first into an HW3_dp detector and tallies its hits.
module hw3_det_ctrl
    import hw3_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int FIND_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic              i_word_valid,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_word_ready,
    input  logic [CNT_W-1:0]  i_thresh,
    input  logic              i_find,
    output logic              o_det_data,
    output logic              o_det_rst_n,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_match_cnt,
    output logic              o_irq
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DC_W = $clog2(FIND_LAT + 1);

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [DC_W-1:0] DC_INIT = DC_W'(FIND_LAT);
    localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);

    state_e            state_q, state_d;
    logic              en_q;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    logic              det_data_q, det_data_d;
    logic              det_rst_n_q, det_rst_n_d;
    logic              accept;

    // A new word may enter from IDLE or on the last bit of the current one, so the stream has no bubbles.
    assign o_word_ready = en_q && !i_clear &&
                          ((state_q == IDLE) || ((state_q == SHIFT) && (bitcnt_q == '0)));
    assign accept       = i_word_valid && o_word_ready;

    // Next-state and shifter logic; the serial bit is precomputed so o_det_data comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        drain_d  = drain_q;
        if (i_clear) begin
            state_d  = IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
            drain_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_d  = i_word;
                        bitcnt_d = BC_LAST;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bitcnt_q != '0) begin
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q - BC_ONE;
                    end else if (accept) begin
                        shreg_d  = i_word;
                        bitcnt_d = BC_LAST;
                    end else begin
                        shreg_d = '0;
                        drain_d = DC_INIT;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_q <= DC_ONE) begin
                        drain_d = '0;
                        state_d = IDLE;
                    end else begin
                        drain_d = drain_q - DC_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        det_data_d  = (state_d == SHIFT) ? shreg_d[WORD_W-1] : 1'b0;
        det_rst_n_d = !i_clear;
    end

    // Controller registers; the detector is held in reset until the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            drain_q     <= '0;
            det_data_q  <= 1'b0;
            det_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= i_enable;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            drain_q     <= drain_d;
            det_data_q  <= det_data_d;
            det_rst_n_q <= det_rst_n_d;
        end
    end

    assign o_det_data  = det_data_q;
    assign o_det_rst_n = det_rst_n_q;
    assign o_busy      = (state_q != IDLE);

    hw3_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (i_clear),
        .i_find   (i_find),
        .i_thresh (i_thresh),
        .o_cnt    (o_match_cnt),
        .o_irq    (o_irq)
    );

endmodule

// File: tb/tb_hw3_det_ctrl.sv
// Bench for hw3_det_ctrl with a behavioural HW3_dp detector and a serial-bit scoreboard.
module tb_hw3_det_ctrl;
    import hw3_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       word_valid = 1'b0;
    logic [7:0] word = 8'h00;
    logic [7:0] thresh = 8'h00;
    logic       find = 1'b0;
    logic [6:0] det_sr = 7'h00;

    logic       word_ready, det_data, det_rst_n, busy, irq;
    logic [7:0] match_cnt;
    logic       word_ready2, det_data2, det_rst_n2, busy2, irq2;
    logic [1:0] match_cnt2;

    int checks = 0;
    int failures = 0;

    // Scoreboard state: serial bits owed by the DUT and a reference detector/counter.
    logic bit_q[$];
    logic [6:0] hist = 7'h00;
    logic pend = 1'b0;
    logic exp_bit;
    int exp_cnt = 0;
    int exp_cnt2 = 0;
    logic exp_irq = 1'b0;

    always #5 clk = ~clk;

    hw3_det_ctrl #(.WORD_W(8), .CNT_W(8), .FIND_LAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_clear(clear),
        .i_word_valid(word_valid), .i_word(word), .o_word_ready(word_ready),
        .i_thresh(thresh), .i_find(find), .o_det_data(det_data),
        .o_det_rst_n(det_rst_n), .o_busy(busy), .o_match_cnt(match_cnt), .o_irq(irq)
    );

    hw3_det_ctrl #(.WORD_W(8), .CNT_W(2), .FIND_LAT(1)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_clear(clear),
        .i_word_valid(word_valid), .i_word(word), .o_word_ready(word_ready2),
        .i_thresh(thresh[1:0]), .i_find(find), .o_det_data(det_data2),
        .o_det_rst_n(det_rst_n2), .o_busy(busy2), .o_match_cnt(match_cnt2), .o_irq(irq2)
    );

    // Behavioural HW3_dp: registered overlapping detector, one cycle from last bit to find.
    always @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            det_sr <= 7'h00;
            find   <= 1'b0;
        end else begin
            det_sr <= {det_sr[5:0], det_data};
            find   <= pattern_hit({det_sr[5:0], det_data});
        end
    end

    // Scoreboard: compare each serial bit and the counters, then advance the reference model.
    always @(negedge clk) begin
        if (!rst_n) begin
            bit_q.delete();
            hist = 7'h00; pend = 1'b0; exp_cnt = 0; exp_cnt2 = 0; exp_irq = 1'b0;
        end else begin
            exp_bit = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b0;
            checks++;
            if (det_data !== exp_bit) begin
                failures++;
                $display("[TB] FAIL det_data @%0t: got %b expected %b", $time, det_data, exp_bit);
            end
            checks++;
            if (match_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("[TB] FAIL match_cnt @%0t: got %0d expected %0d", $time, match_cnt, exp_cnt);
            end
            checks++;
            if (match_cnt2 !== 2'(exp_cnt2)) begin
                failures++;
                $display("[TB] FAIL match_cnt_sat @%0t: got %0d expected %0d", $time, match_cnt2, exp_cnt2);
            end
            checks++;
            if (irq !== exp_irq) begin
                failures++;
                $display("[TB] FAIL irq @%0t: got %b expected %b", $time, irq, exp_irq);
            end
            if (clear) begin
                bit_q.delete();
                hist = 7'h00; pend = 1'b0; exp_cnt = 0; exp_cnt2 = 0; exp_irq = 1'b0;
            end else begin
                if (pend) begin
                    if (exp_cnt < 255) exp_cnt++;
                    if (exp_cnt2 < 3) exp_cnt2++;
                    if ((exp_cnt == int'(thresh)) && (thresh != 8'h00)) exp_irq = 1'b1;
                end
                hist = {hist[5:0], exp_bit};
                pend = pattern_hit(hist);
                if (word_valid && word_ready) begin
                    for (int b = 7; b >= 0; b--) bit_q.push_back(word[b]);
                end
            end
        end
    end

    // Offer up to three words in turn, holding valid until each is taken.
    task automatic drive_words(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input int n);
        logic [7:0] ws[3];
        logic got;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        for (int i = 0; i < n; i++) begin
            word = ws[i];
            word_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (word_ready) got = 1'b1;
            end
            if (!got) begin
                checks++; failures++;
                $display("[TB] FAIL accept_timeout: word %0h not taken, required within 40 cycles", ws[i]);
            end
            @(posedge clk); #1;
        end
        word_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL idle_timeout: busy still %b, required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({word_ready, det_data, det_rst_n, busy, irq, match_cnt} !== 13'h0) begin
            failures++;
            $display("[TB] FAIL reset_values: got rdy=%b dat=%b drst=%b busy=%b irq=%b cnt=%0d, required all 0",
                     word_ready, det_data, det_rst_n, busy, irq, match_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (det_rst_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL det_rst_release: got %b required 1", det_rst_n);
        end
        checks++;
        if (word_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_without_enable: got %b required 0", word_ready);
        end
    endtask

    task automatic test_basic_stream();
        thresh = 8'd0;
        enable = 1'b1;
        drive_words(8'h00, 8'hDB, 8'h6D, 3);
        wait_idle();
        checks++;
        if (match_cnt !== 8'd4) begin
            failures++;
            $display("[TB] FAIL basic_count: got %0d required 4", match_cnt);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_irq_disabled: got %b required 0", irq);
        end
    endtask

    task automatic test_threshold_irq();
        int nf;
        pulse_clear();
        thresh = 8'd3;
        nf = 0;
        fork
            drive_words(8'h00, 8'hDB, 8'h6D, 3);
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    checks++;
                    if (irq !== (nf >= 3)) begin
                        failures++;
                        $display("[TB] FAIL irq_timing: after %0d finds irq=%b, required %b", nf, irq, (nf >= 3));
                    end
                    if (find) nf++;
                end
            end
        join
        wait_idle();
        checks++;
        if ({match_cnt, irq} !== {8'd4, 1'b1}) begin
            failures++;
            $display("[TB] FAIL irq_final: got cnt=%0d irq=%b, required cnt=4 irq=1", match_cnt, irq);
        end
    endtask

    task automatic test_nomatch_ready();
        int accepts;
        pulse_clear();
        thresh = 8'd1;
        word = 8'hFF;
        word_valid = 1'b1;
        accepts = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checks++;
            if (word_ready !== ((i % 8) == 0)) begin
                failures++;
                $display("[TB] FAIL ready_pulse: cycle %0d got %b required %b", i, word_ready, ((i % 8) == 0));
            end
            if (word_ready && word_valid) accepts++;
            @(posedge clk); #1;
            if (accepts == 3) word_valid = 1'b0;
        end
        wait_idle();
        checks++;
        if ({match_cnt, irq} !== 9'h0) begin
            failures++;
            $display("[TB] FAIL nomatch: got cnt=%0d irq=%b, required cnt=0 irq=0", match_cnt, irq);
        end
    endtask

    task automatic test_clear_mid_word();
        thresh = 8'd2;
        drive_words(8'hDB, 8'h6D, 8'h00, 2);
        wait_idle();
        drive_words(8'hDB, 8'h00, 8'h00, 1);
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if ({busy, irq, det_rst_n, det_data, match_cnt} !== 12'h0) begin
            failures++;
            $display("[TB] FAIL clear_effect: got busy=%b irq=%b drst=%b dat=%b cnt=%0d, required all 0",
                     busy, irq, det_rst_n, det_data, match_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (det_rst_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clear_rst_pulse: got %b required 1", det_rst_n);
        end
        word = 8'hDB;
        word_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_during_clear: got %b required 0", word_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        word_valid = 1'b0;
        checks++;
        if ({busy, det_rst_n} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL clear_blocks_accept: got busy=%b drst=%b, required 0 0", busy, det_rst_n);
        end
        drive_words(8'hDB, 8'h6D, 8'h00, 2);
        wait_idle();
        checks++;
        if (match_cnt !== 8'd4) begin
            failures++;
            $display("[TB] FAIL after_clear_count: got %0d required 4", match_cnt);
        end
    endtask

    task automatic test_disable_mid_word();
        pulse_clear();
        thresh = 8'd0;
        drive_words(8'hDB, 8'h00, 8'h00, 1);
        @(posedge clk); #1;
        word = 8'h6D;
        word_valid = 1'b1;
        enable = 1'b0;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, word_ready} !== {(i <= 9), 1'b0}) begin
                failures++;
                $display("[TB] FAIL disable_drain: cycle %0d got busy=%b rdy=%b, required busy=%b rdy=0",
                         i, busy, word_ready, (i <= 9));
            end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_latency: got %b required 0", word_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reenable_ready: got %b required 1", word_ready);
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        wait_idle();
        checks++;
        if (match_cnt !== 8'd2) begin
            failures++;
            $display("[TB] FAIL disable_count: got %0d required 2", match_cnt);
        end
    endtask

    task automatic test_saturation_and_async_reset();
        pulse_clear();
        thresh = 8'd0;
        drive_words(8'hDB, 8'h6D, 8'h00, 2);
        wait_idle();
        checks++;
        if ({match_cnt2, match_cnt} !== {2'd3, 8'd4}) begin
            failures++;
            $display("[TB] FAIL saturation: got cnt2=%0d cnt=%0d, required cnt2=3 cnt=4", match_cnt2, match_cnt);
        end
        drive_words(8'hDB, 8'h00, 8'h00, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({word_ready, det_data, det_rst_n, busy, irq, match_cnt,
             word_ready2, det_data2, det_rst_n2, busy2, irq2, match_cnt2} !== 20'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: got rdy=%b dat=%b drst=%b busy=%b irq=%b cnt=%0d cnt2=%0d busy2=%b, required all 0",
                     word_ready, det_data, det_rst_n, busy, irq, match_cnt, match_cnt2, busy2);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({det_rst_n, busy} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL post_reset: got drst=%b busy=%b, required 1 0", det_rst_n, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_threshold_irq();
        test_nomatch_ready();
        test_clear_mid_word();
        test_disable_mid_word();
        test_saturation_and_async_reset();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
